// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus shared by the program loader
// and its environment.
interface imem_loader_if #(
  parameter int AW = 10
) ();
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;

  // loader side
  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  // byte source / memory side
  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian byte pairs into 16-bit instruction words,
// writes them from address 0 upward and releases the CPU once a halt word lands.
module imem_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  imem_loader_if.master bus,
  output logic          cpu_run,
  output logic          done,
  output logic          error,
  output logic [AW:0]   word_count
);

  typedef enum logic [2:0] {
    LOAD_HI = 3'd0,
    LOAD_LO = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [15:0]   HALT_WORD = 16'hFFFF;

  state_t        state_r;
  logic [AW-1:0] addr_r;
  logic [15:0]   word_r;
  logic          hs_s;

  assign hs_s = bus.rx_valid & bus.rx_ready;

  // Load FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= LOAD_HI;
      addr_r        <= '0;
      word_r        <= 16'h0000;
      word_count    <= '0;
      bus.rx_ready  <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 16'h0000;
      done          <= 1'b0;
      error         <= 1'b0;
      cpu_run       <= 1'b0;
    end else begin
      case (state_r)
        LOAD_HI: begin
          if (hs_s) begin
            word_r[15:8] <= bus.rx_data;
            state_r      <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (hs_s) begin
            word_r[7:0]   <= bus.rx_data;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_r;
            bus.mem_wdata <= {word_r[15:8], bus.rx_data};
            bus.rx_ready  <= 1'b0;
            state_r       <= WRITE;
          end
        end
        WRITE: begin
          bus.mem_we <= 1'b0;
          word_count <= word_count + (AW+1)'(1);
          // A halt word at the last address still counts as a clean finish.
          if (word_r == HALT_WORD) begin
            done    <= 1'b1;
            cpu_run <= 1'b1;
            state_r <= DONE;
          end else if (addr_r == LAST_ADDR) begin
            error   <= 1'b1;
            state_r <= ERROR;
          end else begin
            addr_r       <= addr_r + AW'(1);
            bus.rx_ready <= 1'b1;
            state_r      <= LOAD_HI;
          end
        end
        DONE: begin
          bus.rx_ready <= 1'b0;
          bus.mem_we   <= 1'b0;
        end
        ERROR: begin
          bus.rx_ready <= 1'b0;
          bus.mem_we   <= 1'b0;
        end
        default: begin
          // Unreachable encoding: park safely with the CPU held.
          bus.rx_ready <= 1'b0;
          bus.mem_we   <= 1'b0;
          cpu_run      <= 1'b0;
          error        <= 1'b1;
          state_r      <= ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader with a small memory so the
// fill-without-halt boundary is reachable.
module tb_imem_loader;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            kind;   // 0 plain, 1 halt, 2 last slot without halt
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_run, done, error;
  logic [AW:0] word_count;

  imem_loader_if #(.AW(AW)) bus_if ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_if.master),
    .cpu_run    (cpu_run),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   post_kind = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write is popped against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (post_kind == 1) begin
      chk("done_after_halt", done, 1);
      chk("cpu_run_after_halt", cpu_run, 1);
    end else if (post_kind == 2) begin
      chk("error_after_fill", error, 1);
      chk("cpu_run_low_on_error", cpu_run, 0);
    end
    post_kind = 0;
    if (!reset && bus_if.mem_we === 1'b1) begin
      chk("rx_ready_in_write", bus_if.rx_ready, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required no write",
                 bus_if.mem_addr, bus_if.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", bus_if.mem_addr, e.addr);
        chk("write_data", bus_if.mem_wdata, e.data);
        chk("done_low_during_write", done, 0);
        post_kind = e.kind;
      end
    end
  end

  // Reference: pair bytes into words, stop at a halt word or a full memory.
  function automatic void model(input bq_t b, output int consumed, output int nwr,
                                output bit fin_done, output bit fin_err);
    exp_t e;
    nwr = 0; fin_done = 1'b0; fin_err = 1'b0;
    for (int i = 0; (2*i + 1 < b.size()) && !fin_done && !fin_err; i++) begin
      e.addr = AW'(i);
      e.data = {b[2*i], b[2*i+1]};
      e.kind = (e.data == 16'hFFFF) ? 1 : ((i == DEPTH - 1) ? 2 : 0);
      exp_q.push_back(e);
      nwr++;
      if (e.kind == 1) fin_done = 1'b1;
      if (e.kind == 2) fin_err  = 1'b1;
    end
    consumed = (fin_done || fin_err) ? 2*nwr : b.size();
  endfunction

  task automatic do_reset(input logic [7:0] junk);
    reset = 1'b1;
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = junk;
    @(posedge clock); #1;
    reset = 1'b0;
    bus_if.rx_valid = 1'b0;
    @(negedge clock);
    chk("reset_mem_we", bus_if.mem_we, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_cpu_run", cpu_run, 0);
    chk("reset_word_count", word_count, 0);
    chk("reset_rx_ready", bus_if.rx_ready, 1);
    chk("reset_scoreboard_empty", exp_q.size(), 0);
    @(posedge clock); #1;
  endtask

  task automatic run_seq(input bq_t b, input int gap_min, input int gap_max);
    int consumed, nwr, gap, t;
    bit fd, fe;
    model(b, consumed, nwr, fd, fe);
    for (int i = 0; i < b.size(); i++) begin
      gap = int'($urandom_range(gap_max, gap_min));
      bus_if.rx_valid = 1'b0;
      repeat (gap) begin @(posedge clock); #1; end
      bus_if.rx_valid = 1'b1;
      bus_if.rx_data  = b[i];
      if (i < consumed) begin
        t = 0;
        forever begin
          @(negedge clock);
          if (bus_if.rx_ready === 1'b1 || t > 20) break;
          t++;
        end
        if (t > 20) begin
          checks++;
          errors++;
          $display("FAIL handshake_timeout actual rx_ready=0 for 20 cycles required byte %0d accepted", i);
        end
        @(posedge clock); #1;
      end else begin
        repeat (4) begin
          @(negedge clock);
          chk("no_consume_after_terminal", bus_if.rx_ready, 0);
        end
        @(posedge clock); #1;
      end
    end
    bus_if.rx_valid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_done", done, fd);
    chk("final_error", error, fe);
    chk("final_cpu_run", cpu_run, fd);
    chk("final_word_count", word_count, nwr);
    chk("final_rx_ready", bus_if.rx_ready, !(fd || fe));
    @(posedge clock); #1;
  endtask

  initial begin
    bq_t b;
    int  len;
    reset = 1'b1;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    @(posedge clock); #1;

    do_reset(8'h55);
    run_seq('{8'h71, 8'h0F, 8'hFF, 8'hFF}, 0, 0);
    do_reset(8'h55);
    run_seq('{8'h20, 8'h40}, 5, 5);
    do_reset(8'h00);
    run_seq('{8'h11, 8'h22, 8'hAA, 8'hBB, 8'hFF, 8'hFF}, 0, 0);
    do_reset(8'hFF);
    run_seq('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A}, 0, 1);
    do_reset(8'h00);
    run_seq('{8'h12}, 0, 0);
    do_reset(8'h34);
    run_seq('{8'hAB, 8'hCD, 8'hFF, 8'hFF}, 0, 0);
    do_reset(8'h00);
    run_seq('{8'h71, 8'h0F, 8'hFF, 8'hFF, 8'h00, 8'h01}, 0, 0);
    do_reset(8'h00);
    run_seq('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFF, 8'hFF}, 0, 0);

    for (int n = 0; n < 40; n++) begin
      b = {};
      len = int'($urandom_range(6, 0));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(4, 0) == 0) begin
          b.push_back(8'hFF);
          b.push_back(8'hFF);
        end else begin
          b.push_back(8'($urandom));
          b.push_back(8'($urandom));
        end
      end
      if ($urandom_range(1, 0) == 1) b.push_back(8'($urandom));
      do_reset(8'($urandom));
      run_seq(b, 0, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
